multdiv_seq: RTL and testbench

Sequencer for the shared iterative multiply/divide datapath in the CPU's multdiv unit. It accepts a start pulse from the pipeline, latches the operands and walks the datapath through its iterations. Multiply is radix-4 modified Booth with 16 steps; divide is restoring with 32 steps. When the datapath finishes, the block captures the result and raises a one-cycle ready strobe with exception status, which the pipeline uses to release its stall.

---
 rtl/multdiv_seq.sv | 152 +++++++++++++++
 tb/tb_multdiv_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Latches operands, steps the datapath, and captures result/exception.
module multdiv_seq #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int COUNT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    input  logic [31:0]        operandA,
    input  logic [31:0]        operandB,
    output logic [31:0]        op_a_q,
    output logic [31:0]        op_b_q,
    output logic               is_mult,
    output logic               init,
    output logic               step_en,
    output logic [COUNT_W-1:0] count,
    input  logic [31:0]        dp_result,
    input  logic               dp_overflow,
    output logic [31:0]        data_result,
    output logic               data_exception,
    output logic               data_resultRDY,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [COUNT_W-1:0] MULT_LAST = COUNT_W'(MULT_STEPS - 1);
    localparam logic [COUNT_W-1:0] DIV_LAST  = COUNT_W'(DIV_STEPS - 1);

    state_e             state_q, state_d;
    logic [31:0]        op_a_d, op_b_d;
    logic               is_mult_q, is_mult_d;
    logic               dz_q, dz_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               init_q, init_d;
    logic               step_en_q, step_en_d;
    logic               busy_q, busy_d;
    logic [31:0]        result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic               start;
    logic [COUNT_W-1:0] last;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last  = is_mult_q ? MULT_LAST : DIV_LAST;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        is_mult_d = is_mult_q;
        dz_d      = dz_q;
        count_d   = '0;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;

        // A start aborts whatever is in flight, including a pending capture.
        if (start) begin
            state_d   = INIT;
            op_a_d    = operandA;
            op_b_d    = operandB;
            is_mult_d = ctrl_MULT;
            dz_d      = 1'b0;
            result_d  = '0;
            exc_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                INIT: begin
                    if (!is_mult_q && (op_b_q == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (count_q >= last) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    result_d = dz_q ? '0 : dp_result;
                    exc_d    = dz_q | (is_mult_q & dp_overflow);
                    rdy_d    = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        init_d    = (state_d == INIT);
        step_en_d = (state_d == RUN);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            is_mult_q <= 1'b0;
            dz_q      <= 1'b0;
            count_q   <= '0;
            init_q    <= 1'b0;
            step_en_q <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            is_mult_q <= is_mult_d;
            dz_q      <= dz_d;
            count_q   <= count_d;
            init_q    <= init_d;
            step_en_q <= step_en_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
        end
    end

    assign is_mult        = is_mult_q;
    assign init           = init_q;
    assign step_en        = step_en_q;
    assign count          = count_q;
    assign busy           = busy_q;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq with a cycle-timeline reference model
// and a behavioural datapath stand-in driving dp_result/dp_overflow.
module tb_multdiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic [31:0] op_a_q, op_b_q;
    logic        is_mult, init, step_en, busy;
    logic [5:0]  count;
    logic [31:0] dp_result;
    logic        dp_overflow;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    bit          ovf_sel = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    multdiv_seq #(.MULT_STEPS(16), .DIV_STEPS(32), .COUNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .operandA(operandA), .operandB(operandB),
        .op_a_q(op_a_q), .op_b_q(op_b_q), .is_mult(is_mult),
        .init(init), .step_en(step_en), .count(count),
        .dp_result(dp_result), .dp_overflow(dp_overflow),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: meaningful values only in the DONE cycle.
    always_comb begin
        dp_result   = 32'hA5A5_5A5A;
        dp_overflow = 1'b1;
        if (busy && !init && !step_en) begin
            dp_overflow = ovf_sel;
            if (is_mult)
                dp_result = op_a_q * op_b_q;
            else if (op_b_q != 0)
                dp_result = op_a_q / op_b_q;
            else
                dp_result = 32'hDEAD_BEEF;
        end
    end

    typedef struct {
        int          s;
        int          n;
        bit          dz;
        logic [31:0] a;
        logic [31:0] b;
        bit          m;
    } op_t;

    typedef struct {
        logic [31:0] res;
        bit          exc;
        int          cyc;
    } exp_t;

    op_t  ops[$];
    exp_t sb[$];
    int   clr_q[$];
    int   rst_hist[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    // Drop the pending result if the new event lands before its RDY cycle.
    task automatic abort_pending();
        if (sb.size() > 0 && cyc < sb[$].cyc) void'(sb.pop_back());
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(bit pm, bit pd, logic [31:0] a, logic [31:0] b,
                            bit ovf);
        op_t  o;
        exp_t e;
        abort_pending();
        o.s  = cyc;
        o.m  = pm;
        o.dz = !pm && (b == 0);
        o.n  = pm ? 16 : 32;
        o.a  = a;
        o.b  = b;
        ops.push_back(o);
        if (o.dz)      e.res = 32'd0;
        else if (o.m)  e.res = a * b;
        else           e.res = a / b;
        e.exc = o.dz | (o.m & ovf);
        e.cyc = cyc + (o.dz ? 3 : o.n + 3);
        sb.push_back(e);
        clr_q.push_back(cyc + 1);
        ctrl_MULT = pm;
        ctrl_DIV  = pd;
        operandA  = a;
        operandB  = b;
        ovf_sel   = ovf;
        @(posedge clk);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = $urandom;
        operandB  = $urandom;
    endtask

    task automatic do_reset();
        abort_pending();
        rst_hist.push_back(cyc + 1);
        clr_q.push_back(cyc + 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] hold_res = '0;
    bit          hold_exc = 1'b0;

    always @(negedge clk) begin : monitor
        int   r, rel, d;
        bit   found, alive;
        bit   e_init, e_step, e_busy, e_m;
        int   e_cnt;
        logic [31:0] e_a, e_b;
        op_t  o;
        exp_t e;
        if (mon_en) begin
            r = -1;
            foreach (rst_hist[i]) if (rst_hist[i] <= cyc) r = rst_hist[i];
            found = 1'b0;
            for (int i = ops.size() - 1; i >= 0; i--) begin
                if (ops[i].s + 1 <= cyc) begin
                    o = ops[i];
                    found = 1'b1;
                    break;
                end
            end
            alive  = found && (o.s >= r);
            e_init = 1'b0; e_step = 1'b0; e_busy = 1'b0; e_m = 1'b0;
            e_cnt  = 0; e_a = '0; e_b = '0;
            if (alive) begin
                rel    = cyc - o.s;
                d      = o.dz ? 2 : o.n + 2;
                e_init = (rel == 1);
                e_step = !o.dz && rel >= 2 && rel <= o.n + 1;
                e_cnt  = e_step ? rel - 2 : 0;
                e_busy = rel >= 1 && rel <= d;
                e_m    = o.m;
                e_a    = o.a;
                e_b    = o.b;
            end
            chk("init", 32'(init), 32'(e_init));
            chk("step_en", 32'(step_en), 32'(e_step));
            chk("count", 32'(count), 32'(e_cnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("is_mult", 32'(is_mult), 32'(e_m));
            chk("op_a_q", op_a_q, e_a);
            chk("op_b_q", op_b_q, e_b);

            while (clr_q.size() > 0 && clr_q[0] <= cyc) begin
                void'(clr_q.pop_front());
                hold_res = '0;
                hold_exc = 1'b0;
            end
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    chk("spurious_rdy", 32'(data_resultRDY), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
                    hold_res = e.res;
                    hold_exc = e.exc;
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("rdy_missing", 32'(data_resultRDY), 32'd1);
                void'(sb.pop_front());
            end
            chk("data_result", data_result, hold_res);
            chk("data_exception", 32'(data_exception), 32'(hold_exc));
        end
    end

    initial begin
        rst_hist.push_back(0);
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(3);

        start_op(1, 0, 32'd7, -32'sd3, 0);      idle(22);
        start_op(0, 1, 32'd100, 32'd7, 0);      idle(38);
        start_op(0, 1, 32'd5, 32'd0, 0);        idle(6);
        start_op(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1); idle(22);
        start_op(0, 1, 32'd1000, 32'd3, 1);     idle(38);

        start_op(1, 0, 32'd11, 32'd13, 0);      idle(9);
        start_op(0, 1, 32'd1000, 32'd9, 0);     idle(40);

        start_op(1, 0, 32'd3, 32'd4, 0);        idle(7);
        do_reset();                             idle(30);

        start_op(1, 1, 32'd6, 32'd7, 0);        idle(22);

        start_op(1, 0, 32'd9, 32'd9, 0);        idle(18);
        start_op(0, 1, 32'd77, 32'd5, 0);       idle(40);

        for (int i = 0; i < 30; i++) begin
            int          k;
            logic [31:0] a, b;
            k = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (k == 0)      do_reset();
            else if (k < 4)  start_op(1, 0, a, b, 1'($urandom_range(0, 1)));
            else if (k < 9)  start_op(0, 1, a, b, 1'($urandom_range(0, 1)));
            else             start_op(1, 1, a, b, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 40));
        end
        idle(40);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
